// File: rtl/aliens_motion_ctrl.sv
// Motion sequencer for the alien block: paces LEFT/RIGHT/DOWN step pulses,
// speeds up on each kill and freezes once the game is won or lost.
module aliens_motion_ctrl #(
  parameter int TICK_DIV   = 1000000,
  parameter int SPEEDUP    = 20000,
  parameter int MIN_DIV    = 100000,
  parameter int DOWN_STEPS = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       canLeft,
  input  logic       canRight,
  input  logic       killingAlien,
  input  logic       victory,
  input  logic       defeat,
  output logic [1:0] motion,
  output logic       dirRight,
  output logic       halted
);

  typedef enum logic [1:0] {IDLE, MOVE_H, DESCEND, HALT} state_t;

  localparam logic [1:0]  M_NONE  = 2'd0;
  localparam logic [1:0]  M_LEFT  = 2'd1;
  localparam logic [1:0]  M_RIGHT = 2'd2;
  localparam logic [1:0]  M_DOWN  = 2'd3;
  localparam logic [23:0] TICK24  = 24'(TICK_DIV);
  localparam logic [23:0] SPEED24 = 24'(SPEEDUP);
  localparam logic [23:0] MIN24   = 24'(MIN_DIV);
  localparam logic [7:0]  DOWN_M1 = 8'(DOWN_STEPS - 1);
  localparam logic [24:0] FLOOR25 = 25'(MIN_DIV) + 25'(SPEEDUP);

  state_t      state;
  logic [23:0] period;
  logic [23:0] tick;
  logic [7:0]  down_cnt;
  logic        kill_prev;
  logic        kill_edge;
  logic        stop_game;

  assign kill_edge = killingAlien & ~kill_prev;
  assign stop_game = victory | defeat;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      motion    <= M_NONE;
      dirRight  <= 1'b1;
      halted    <= 1'b0;
      period    <= TICK24;
      tick      <= 24'd0;
      down_cnt  <= 8'd0;
      kill_prev <= 1'b0;
    end else begin
      kill_prev <= killingAlien;
      motion    <= M_NONE;
      // The new period only takes effect at the next reload of the tick counter.
      if (state != HALT && kill_edge) begin
        period <= ({1'b0, period} >= FLOOR25) ? period - SPEED24 : MIN24;
      end
      case (state)
        IDLE: begin
          if (stop_game) begin
            state  <= HALT;
            halted <= 1'b1;
          end else if (start) begin
            state <= MOVE_H;
            tick  <= period - 24'd1;
          end
        end
        MOVE_H, DESCEND: begin
          if (stop_game) begin
            state  <= HALT;
            halted <= 1'b1;
          end else if (tick != 24'd0) begin
            tick <= tick - 24'd1;
          end else begin
            tick <= period - 24'd1;
            if (state == MOVE_H) begin
              if (dirRight && canRight) begin
                motion <= M_RIGHT;
              end else if (!dirRight && canLeft) begin
                motion <= M_LEFT;
              end else begin
                // Edge hit: first DOWN now, remaining ones from DESCEND.
                motion   <= M_DOWN;
                down_cnt <= DOWN_M1;
                dirRight <= ~dirRight;
                if (DOWN_STEPS > 1) state <= DESCEND;
              end
            end else begin
              motion <= M_DOWN;
              if (down_cnt <= 8'd1) begin
                down_cnt <= 8'd0;
                state    <= MOVE_H;
              end else begin
                down_cnt <= down_cnt - 8'd1;
              end
            end
          end
        end
        default: halted <= 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_aliens_motion_ctrl.sv
// Randomized bench for aliens_motion_ctrl: a step-time reference model feeds an
// expected queue that a negedge monitor drains whenever the DUT pulses motion.
module tb_aliens_motion_ctrl;

  localparam int TD = 4;
  localparam int SU = 1;
  localparam int MD = 2;
  localparam int DS = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       can_left = 1'b1;
  logic       can_right = 1'b1;
  logic       kill = 1'b0;
  logic       victory = 1'b0;
  logic       defeat = 1'b0;
  logic [1:0] motion;
  logic       dir_right;
  logic       halted;

  int checks = 0;
  int errors = 0;

  aliens_motion_ctrl #(
    .TICK_DIV(TD), .SPEEDUP(SU), .MIN_DIV(MD), .DOWN_STEPS(DS)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .canLeft(can_left),
    .canRight(can_right), .killingAlien(kill), .victory(victory),
    .defeat(defeat), .motion(motion), .dirRight(dir_right), .halted(halted)
  );

  always #5 clk = ~clk;

  // Reference model: steps happen at absolute cycle numbers spaced by the
  // period in force when the previous step (or start) happened.
  int         cyc = 0;
  int         m_period = TD;
  int         m_next = 0;
  int         m_down_left = 0;
  bit         m_run = 0;
  bit         m_halted = 0;
  bit         m_dir = 1;
  bit         m_kill_prev = 0;
  logic [1:0] mot;
  logic [34:0] exp_q[$];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_run = 0; m_halted = 0; m_dir = 1; m_period = TD;
      m_down_left = 0; m_kill_prev = 0;
    end else begin
      cyc = cyc + 1;
      if (!m_halted) begin
        if (victory || defeat) begin
          m_halted = 1; m_run = 0;
        end else if (!m_run) begin
          if (start) begin m_run = 1; m_next = cyc + m_period; end
        end else if (cyc == m_next) begin
          if (m_down_left > 0) begin
            mot = 2'd3; m_down_left = m_down_left - 1;
          end else if (m_dir ? can_right : can_left) begin
            mot = m_dir ? 2'd2 : 2'd1;
          end else begin
            mot = 2'd3; m_dir = !m_dir; m_down_left = DS - 1;
          end
          exp_q.push_back({32'(cyc), mot, m_dir});
          m_next = cyc + m_period;
        end
        if (kill && !m_kill_prev) m_period = (m_period - SU < MD) ? MD : m_period - SU;
      end
      m_kill_prev = kill;
    end
  end

  // Monitor: pops an expectation whenever the DUT shows a step pulse.
  logic [34:0] e;
  always @(negedge clk) begin
    if (!reset) begin
      if (motion != 2'd0) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_motion cyc=%0d got motion=%0d expected none", cyc, motion);
        end else begin
          e = exp_q.pop_front();
          if (e[34:3] != 32'(cyc) || e[2:1] != motion || e[0] != dir_right) begin
            errors++;
            $display("FAIL step cyc=%0d got motion=%0d dir=%0d expected cyc=%0d motion=%0d dir=%0d",
                     cyc, motion, dir_right, e[34:3], e[2:1], e[0]);
          end
        end
      end else if (exp_q.size() > 0 && int'(exp_q[0][34:3]) < cyc) begin
        checks++; errors++;
        e = exp_q.pop_front();
        $display("FAIL missing_step cyc=%0d got motion=0 expected motion=%0d at cyc=%0d",
                 cyc, e[2:1], e[34:3]);
      end
      checks++;
      if (halted !== m_halted || dir_right !== m_dir) begin
        errors++;
        $display("FAIL status cyc=%0d got halted=%0d dir=%0d expected halted=%0d dir=%0d",
                 cyc, halted, dir_right, m_halted, m_dir);
      end
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    cycles(2); reset = 1'b0;
  endtask

  task automatic rand_run(input int n, input int kill_pct);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) can_right = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) can_left  = 1'($urandom_range(0, 1));
      kill = ($urandom_range(0, 99) < kill_pct);
    end
    kill = 1'b0;
  endtask

  initial begin
    bit found;
    cycles(2);
    reset = 1'b0;
    chk("reset_motion", motion, 0);
    chk("reset_dir", dir_right, 1);
    chk("reset_halted", halted, 0);

    // Steady right movement, then blocked on the right.
    pulse_start();
    cycles(20);
    can_right = 1'b0;
    cycles(24);
    // Start while moving must not perturb anything.
    pulse_start();
    cycles(12);

    // Kill held 3 cycles, then three separate pulses.
    @(negedge clk); kill = 1'b1;
    cycles(3); kill = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycles(4); kill = 1'b1;
      cycles(1); kill = 1'b0;
    end
    cycles(20);
    chk("period_floor", m_period, MD);

    // Both sides blocked: DOWN bursts with a toggle each hit.
    can_left = 1'b0; can_right = 1'b0;
    cycles(30);
    can_left = 1'b1; can_right = 1'b1;
    rand_run(150, 5);

    // Defeat on the cycle a step is due.
    found = 0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      if (m_run && m_next == cyc + 1) found = 1;
    end
    chk("step_due_found", int'(found), 1);
    defeat = 1'b1;
    @(negedge clk); defeat = 1'b0;
    chk("defeat_motion", motion, 0);
    chk("defeat_halted", halted, 1);
    pulse_start();
    kill = 1'b1; cycles(2); kill = 1'b0; cycles(2); kill = 1'b1;
    cycles(16); kill = 1'b0;
    chk("halt_frozen_motion", motion, 0);
    chk("halt_frozen_halted", halted, 1);

    // Reset asserted asynchronously in the middle of a descent.
    do_reset();
    can_left = 1'b1; can_right = 1'b0;
    pulse_start();
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (m_down_left > 0) found = 1;
    end
    chk("descend_found", int'(found), 1);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_motion", motion, 0);
    chk("async_rst_dir", dir_right, 1);
    chk("async_rst_halted", halted, 0);
    cycles(2); reset = 1'b0;
    cycles(20);
    chk("no_motion_before_start", motion, 0);

    // Random play ending in victory.
    pulse_start();
    rand_run(200, 4);
    @(negedge clk); victory = 1'b1;
    @(negedge clk); victory = 1'b0;
    chk("victory_halted", halted, 1);
    pulse_start();
    rand_run(20, 20);
    chk("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aliens_motion_ctrl.md
ALIENS_MOTION_CTRL -- requirements
Module: aliens_motion_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 1000000, base number of clk cycles between motion steps.
REQ-002 SHALL have parameter SPEEDUP, default 20000, cycles removed from the step period per killed alien.
REQ-003 SHALL have parameter MIN_DIV, default 100000, floor of the step period.
REQ-004 SHALL have parameter DOWN_STEPS, default 1, number of DOWN commands issued per edge hit.
REQ-005 SHALL have port clk  input  1  single system clock, all logic on rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port start  input  1  one-cycle pulse launching the invasion.
REQ-008 SHALL have port canLeft  input  1  aliens block may step left.
REQ-009 SHALL have port canRight  input  1  aliens block may step right.
REQ-010 SHALL have port killingAlien  input  1  kill indication (level; may stay high several cycles).
REQ-011 SHALL have port victory  input  1  all aliens destroyed.
REQ-012 SHALL have port defeat  input  1  aliens reached bottom limit.
REQ-013 SHALL have port motion  output  2  command: 0 none, 1 LEFT, 2 RIGHT, 3 DOWN.
REQ-014 SHALL have port dirRight  output  1  current horizontal direction, 1 = right.
REQ-015 SHALL have port halted  output  1  game over, motion frozen.

Function
REQ-016 SHALL implement FSM states IDLE, MOVE_H, DESCEND, HALT.
REQ-017 SHALL register all outputs; motion SHALL be nonzero for exactly one clk cycle per step (pulse), 0 otherwise.
REQ-018 SHALL hold a 24-bit period register, reset to TICK_DIV, and a 24-bit tick counter.
REQ-019 SHALL, in IDLE, emit motion=0 and move to MOVE_H on the cycle after start=1, loading tick counter with period-1.
REQ-020 SHALL, in MOVE_H/DESCEND, decrement the tick counter each cycle; on reaching 0 a step occurs and the counter reloads with period-1 in the same cycle.
REQ-021 SHALL, on a MOVE_H step with dirRight=1 and canRight=1, emit RIGHT; with dirRight=0 and canLeft=1, emit LEFT.
REQ-022 SHALL, on a MOVE_H step whose direction is blocked, emit DOWN, load down counter with DOWN_STEPS-1, toggle dirRight, and go to DESCEND if DOWN_STEPS>1, else stay in MOVE_H.
REQ-023 SHALL, on each DESCEND step, emit DOWN and decrement the down counter; on the step where it reads 0, return to MOVE_H.
REQ-024 SHALL detect rising edges of killingAlien (registered previous value); each edge reduces period by SPEEDUP, saturating at MIN_DIV (never below, no underflow wrap).
REQ-025 SHALL apply a period change at the next counter reload only; the running count is not altered.
REQ-026 SHALL, when victory=1 or defeat=1 in any non-HALT state, enter HALT next cycle with motion=0 that cycle, even if a step was due (halt wins over step).
REQ-027 SHALL remain in HALT with halted=1, motion=0 until reset; start, kills and can* are ignored.
REQ-028 SHALL ignore start outside IDLE.
REQ-029 SHALL treat canLeft=canRight=0 as blocked in both directions: emit DOWN per REQ-022 and toggle each step.

Reset
REQ-030 SHALL, on reset=1 (asynchronously, also mid-operation), force state IDLE, motion=0, dirRight=1, halted=0, period=TICK_DIV, tick counter=0, down counter=0, kill-edge register=0.
REQ-031 SHALL resume normal operation on the first rising clk edge after reset deasserts.

Verification (TICK_DIV=4, SPEEDUP=1, MIN_DIV=2, DOWN_STEPS=2)
REQ-032 SHALL verify: reset, start pulse, canRight=1 -> motion=2 for one cycle every 4 cycles, dirRight=1.
REQ-033 SHALL verify: canRight drops to 0 -> next two steps motion=3 (4 cycles apart), dirRight=0, then motion=1 steps.
REQ-034 SHALL verify: killingAlien held high 3 cycles, then three separate pulses -> period 4->3->2->2, step spacing 3 then 2 cycles, never below 2.
REQ-035 SHALL verify: defeat=1 on the cycle a step is due -> motion stays 0, halted=1 next cycle, no further motion despite start/kill.
REQ-036 SHALL verify: reset asserted mid-DESCEND -> outputs immediately motion=0, dirRight=1, halted=0; no motion until new start.
REQ-037 SHALL verify: start pulse while in MOVE_H -> no change in step timing or direction.
